// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - two-requester (IFU/LSU) arbiter onto a single-outstanding memory port
module cpu_mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ifu_req_valid,
  input  logic [31:0] i_ifu_req_addr,
  output logic        o_ifu_req_ready,
  output logic        o_ifu_resp_valid,
  output logic [31:0] o_ifu_resp_data,
  output logic        o_ifu_resp_err,
  input  logic        i_lsu_req_valid,
  input  logic [31:0] i_lsu_req_addr,
  input  logic        i_lsu_req_wen,
  input  logic [31:0] i_lsu_req_wdata,
  input  logic [2:0]  i_lsu_req_memop,
  output logic        o_lsu_req_ready,
  output logic        o_lsu_resp_valid,
  output logic [31:0] o_lsu_resp_data,
  output logic        o_lsu_resp_err,
  output logic        o_mem_req_valid,
  output logic [31:0] o_mem_req_addr,
  output logic        o_mem_req_wen,
  output logic [31:0] o_mem_req_wdata,
  output logic [2:0]  o_mem_req_memop,
  input  logic        i_mem_req_ready,
  input  logic        i_mem_resp_valid,
  input  logic [31:0] i_mem_resp_data
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  // Instruction fetches are always full-word accesses.
  localparam logic [2:0] IFU_MEMOP = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_grant_lsu;
  logic [31:0]   r_addr;
  logic          r_wen;
  logic [31:0]   r_wdata;
  logic [2:0]    r_memop;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic w_grant_lsu;
  logic w_grant_ifu;
  logic w_busy;
  logic w_timeout;
  logic w_resp;

  assign w_busy    = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_timeout = (r_cnt == CNT_LAST);
  assign w_resp    = (r_state == S_RESP);

  // Next-state and grant decode; LSU has fixed priority over IFU, and a grant
  // is suppressed while reset is asserted so it can never take effect.
  always_comb begin
    w_next      = r_state;
    w_grant_lsu = 1'b0;
    w_grant_ifu = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_reset) begin
          if (i_lsu_req_valid)      w_grant_lsu = 1'b1;
          else if (i_ifu_req_valid) w_grant_ifu = 1'b1;
        end
        if (w_grant_lsu || w_grant_ifu) w_next = S_REQ;
      end
      S_REQ: begin
        // The deadline wins over a late handshake; any response to it is dropped.
        if (w_timeout)            w_next = S_RESP;
        else if (i_mem_req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_resp_valid || w_timeout) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus latched request, counter and response capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_grant_lsu <= 1'b0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_memop     <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_lsu) begin
        r_grant_lsu <= 1'b1;
        r_addr      <= i_lsu_req_addr;
        r_wen       <= i_lsu_req_wen;
        r_wdata     <= i_lsu_req_wdata;
        r_memop     <= i_lsu_req_memop;
        r_cnt       <= '0;
        r_rdata     <= '0;
        r_err       <= 1'b0;
      end else if (w_grant_ifu) begin
        r_grant_lsu <= 1'b0;
        r_addr      <= i_ifu_req_addr;
        r_wen       <= 1'b0;
        r_wdata     <= '0;
        r_memop     <= IFU_MEMOP;
        r_cnt       <= '0;
        r_rdata     <= '0;
        r_err       <= 1'b0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_state == S_WAIT && i_mem_resp_valid) begin
          r_rdata <= r_wen ? 32'h0 : i_mem_resp_data;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= 32'h0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign o_ifu_req_ready  = w_grant_ifu;
  assign o_lsu_req_ready  = w_grant_lsu;

  assign o_mem_req_valid  = (r_state == S_REQ);
  assign o_mem_req_addr   = r_addr;
  assign o_mem_req_wen    = r_wen;
  assign o_mem_req_wdata  = r_wdata;
  assign o_mem_req_memop  = r_memop;

  assign o_ifu_resp_valid = w_resp && !r_grant_lsu;
  assign o_ifu_resp_data  = (w_resp && !r_grant_lsu) ? r_rdata : 32'h0;
  assign o_ifu_resp_err   = w_resp && !r_grant_lsu && r_err;
  assign o_lsu_resp_valid = w_resp && r_grant_lsu;
  assign o_lsu_resp_data  = (w_resp && r_grant_lsu) ? r_rdata : 32'h0;
  assign o_lsu_resp_err   = w_resp && r_grant_lsu && r_err;

endmodule
